// File: rtl/csr_cmd_sequencer.sv
// csr_cmd_sequencer
//   Initiator side of the CSR access port. Accepts one command at a time
//   (READ / WRITE / SET / CLEAR) and drives it onto the req/gnt/rvalid CSR
//   port. SET and CLEAR run as a read followed by a write of the modified value.
//   Each command returns one response holding the prior CSR value and an error code.
//
//   Optional feature macro: CSR_SEQ_TIMEOUT_EN
//     defined   -> RD_WAIT gives up after TIMEOUT cycles without rvalid (err 2'b10)
//     undefined -> RD_WAIT waits indefinitely
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   cmd_valid_i/ready_o   command handshake; cmd_op_i, cmd_addr_i, cmd_wdata_i payload
//   csr_req_o, csr_we_o,  CSR request, direction, address, write data
//   csr_addr_o, csr_wdata_o
//   csr_gnt_i             request granted
//   csr_rvalid_i, csr_rdata_i, csr_illegal_i  read return / illegal flag
//   rsp_valid_o/ready_i   response handshake; rsp_rdata_o prior value, rsp_err_o code
module csr_cmd_sequencer #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              csr_req_o,
  output logic              csr_we_o,
  output logic [ADDR_W-1:0] csr_addr_o,
  output logic [DATA_W-1:0] csr_wdata_o,
  input  logic              csr_gnt_i,
  input  logic              csr_rvalid_i,
  input  logic [DATA_W-1:0] csr_rdata_i,
  input  logic              csr_illegal_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic [1:0]        rsp_err_o
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_RSP
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] old_q, old_d;
  logic [1:0]        err_q, err_d;

`ifdef CSR_SEQ_TIMEOUT_EN
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  // Value the RD_WAIT counter would take this cycle if rvalid stays low.
  assign cnt_inc = cnt_q + CNT_W'(1);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      err_q   <= ERR_OK;
`ifdef CSR_SEQ_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      err_q   <= err_d;
`ifdef CSR_SEQ_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    err_d   = err_q;
`ifdef CSR_SEQ_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d   = cmd_op_i;
          addr_d = cmd_addr_i;
          mask_d = cmd_wdata_i;
          old_d  = '0;
          err_d  = ERR_OK;
          if (cmd_op_i == OP_WRITE) begin
            wdata_d = cmd_wdata_i;
            state_d = S_WR_REQ;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end

      S_RD_REQ: begin
        if (csr_gnt_i) begin
          state_d = S_RD_WAIT;
`ifdef CSR_SEQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      S_RD_WAIT: begin
        // rvalid is checked first so a return in the expiry cycle still completes normally.
        if (csr_rvalid_i) begin
          old_d = csr_rdata_i;
          if (csr_illegal_i) begin
            err_d   = ERR_ILLEGAL;
            state_d = S_RSP;
          end else if (op_q == OP_READ) begin
            state_d = S_RSP;
          end else begin
            wdata_d = (op_q == OP_SET) ? (csr_rdata_i | mask_q)
                                       : (csr_rdata_i & ~mask_q);
            state_d = S_WR_REQ;
          end
        end
`ifdef CSR_SEQ_TIMEOUT_EN
        else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          err_d   = ERR_TIMEOUT;
          old_d   = '0;
          state_d = S_RSP;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end

      S_WR_REQ: begin
        if (csr_gnt_i) begin
          err_d   = csr_illegal_i ? ERR_ILLEGAL : ERR_OK;
          state_d = S_RSP;
        end
      end

      S_RSP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode from state or come straight from registers; req drops with async reset.
  assign cmd_ready_o = (state_q == S_IDLE);
  assign csr_req_o   = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign csr_we_o    = (state_q == S_WR_REQ);
  assign csr_addr_o  = addr_q;
  assign csr_wdata_o = wdata_q;
  assign rsp_valid_o = (state_q == S_RSP);
  assign rsp_rdata_o = old_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_csr_cmd_sequencer.sv
// tb_csr_cmd_sequencer
//   Acts as the command source, the CSR file and the response sink. The CSR
//   file contents live in an associative array; expected responses and write
//   values come from the command semantics applied to that array.
module tb_csr_cmd_sequencer;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TO     = 15;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [1:0]        cmd_op_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic              csr_req_o;
  logic              csr_we_o;
  logic [ADDR_W-1:0] csr_addr_o;
  logic [DATA_W-1:0] csr_wdata_o;
  logic              csr_gnt_i;
  logic              csr_rvalid_i;
  logic [DATA_W-1:0] csr_rdata_i;
  logic              csr_illegal_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic [1:0]        rsp_err_o;

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

  csr_cmd_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .csr_req_o    (csr_req_o),
    .csr_we_o     (csr_we_o),
    .csr_addr_o   (csr_addr_o),
    .csr_wdata_o  (csr_wdata_o),
    .csr_gnt_i    (csr_gnt_i),
    .csr_rvalid_i (csr_rvalid_i),
    .csr_rdata_i  (csr_rdata_i),
    .csr_illegal_i(csr_illegal_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%08h exp=%08h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  // Present a command for one cycle; afterwards scramble the payload to show it was latched.
  task automatic offer(input logic [1:0] op, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    chk("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_addr_i  = addr;
    cmd_wdata_i = wd;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    cmd_op_i    = 2'($urandom);
    cmd_addr_i  = ADDR_W'($urandom);
    cmd_wdata_i = $urandom;
  endtask

  // One full command: gd_r/gd_w = cycles of withheld gnt, rd = cycles of withheld rvalid,
  // rdy_d = cycles of withheld rsp_ready.
  task automatic run_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input int gd_r, input int rd,
                         input int gd_w, input logic ill_r, input logic ill_w, input int rdy_d);
    logic [DATA_W-1:0] old;
    logic [DATA_W-1:0] nv;
    logic [DATA_W-1:0] exp_rsp;
    logic [1:0]        exp_err;
    bit                do_rd;
    bit                do_wr;

    // Reference behaviour from the command semantics.
    old     = mem_rd(addr);
    do_rd   = (op != OP_WRITE);
    do_wr   = 1'b1;
    nv      = wd;
    exp_rsp = '0;
    exp_err = 2'b00;
    if (do_rd) begin
      exp_rsp = old;
      if (ill_r) begin
        exp_err = 2'b01;
        do_wr   = 1'b0;
      end else if (op == OP_READ) begin
        do_wr = 1'b0;
      end else if (op == OP_SET) begin
        nv = old | wd;
      end else begin
        nv = old & ~wd;
      end
    end
    if (do_wr && ill_w) exp_err = 2'b01;

    offer(op, addr, wd);

    if (do_rd) begin
      for (int i = 0; i <= gd_r; i++) begin
        chk("rd_req", 32'(csr_req_o), 32'd1);
        chk("rd_we", 32'(csr_we_o), 32'd0);
        chk("rd_addr", 32'(csr_addr_o), 32'(addr));
        csr_gnt_i    = (i == gd_r);
        csr_rvalid_i = 1'($urandom);
        @(negedge clk);
      end
      csr_gnt_i = 1'b0;
      for (int i = 0; i <= rd; i++) begin
        chk("rd_wait_req", 32'(csr_req_o), 32'd0);
        chk("rd_wait_rsp", 32'(rsp_valid_o), 32'd0);
        csr_gnt_i     = 1'($urandom);
        csr_rvalid_i  = (i == rd);
        csr_rdata_i   = (i == rd) ? old : DATA_W'($urandom);
        csr_illegal_i = (i == rd) ? ill_r : 1'b0;
        @(negedge clk);
      end
      csr_gnt_i     = 1'b0;
      csr_rvalid_i  = 1'b0;
      csr_illegal_i = 1'b0;
    end

    if (do_wr) begin
      for (int i = 0; i <= gd_w; i++) begin
        chk("wr_req", 32'(csr_req_o), 32'd1);
        chk("wr_we", 32'(csr_we_o), 32'd1);
        chk("wr_addr", 32'(csr_addr_o), 32'(addr));
        chk("wr_data", csr_wdata_o, nv);
        csr_gnt_i     = (i == gd_w);
        csr_illegal_i = (i == gd_w) ? ill_w : 1'b0;
        csr_rvalid_i  = 1'($urandom);
        @(negedge clk);
      end
      csr_gnt_i     = 1'b0;
      csr_illegal_i = 1'b0;
      csr_rvalid_i  = 1'b0;
      if (!ill_w) mem[addr] = nv;
    end

    for (int i = 0; i <= rdy_d; i++) begin
      chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
      chk("rsp_rdata", rsp_rdata_o, exp_rsp);
      chk("rsp_err", 32'(rsp_err_o), 32'(exp_err));
      chk("rsp_no_req", 32'(csr_req_o), 32'd0);
      rsp_ready_i = (i == rdy_d);
      @(negedge clk);
    end
    rsp_ready_i = 1'b0;
    chk("rsp_done", 32'(rsp_valid_o), 32'd0);
  endtask

  // READ whose rvalid never comes (or comes only after a long wait without the timeout).
  task automatic run_timeout(input logic [ADDR_W-1:0] addr);
    offer(OP_READ, addr, 32'h0);
    chk("to_req", 32'(csr_req_o), 32'd1);
    csr_gnt_i = 1'b1;
    @(negedge clk);
    csr_gnt_i = 1'b0;
`ifdef CSR_SEQ_TIMEOUT_EN
    for (int i = 1; i <= int'(TO); i++) begin
      chk("to_waiting", 32'(rsp_valid_o), 32'd0);
      @(negedge clk);
    end
    chk("to_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("to_rsp_err", 32'(rsp_err_o), 32'd2);
    chk("to_rsp_rdata", rsp_rdata_o, 32'd0);
`else
    repeat (100) @(negedge clk);
    chk("nto_still_wait", 32'(rsp_valid_o), 32'd0);
    chk("nto_not_ready", 32'(cmd_ready_o), 32'd0);
    chk("nto_no_req", 32'(csr_req_o), 32'd0);
    csr_rvalid_i = 1'b1;
    csr_rdata_i  = mem_rd(addr);
    @(negedge clk);
    csr_rvalid_i = 1'b0;
    chk("nto_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("nto_rsp_err", 32'(rsp_err_o), 32'd0);
    chk("nto_rsp_rdata", rsp_rdata_o, mem_rd(addr));
`endif
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("to_idle", 32'(cmd_ready_o), 32'd1);
  endtask

  // Reset while a WRITE waits for grant: req falls at once and nothing completes.
  task automatic run_reset_mid_write();
    offer(OP_WRITE, 12'h340, 32'hDEAD_BEEF);
    chk("rst_pre_req", 32'(csr_req_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_req_async", 32'(csr_req_o), 32'd0);
    chk("rst_ready_async", 32'(cmd_ready_o), 32'd1);
    @(negedge clk);
    rst       = 1'b0;
    csr_gnt_i = 1'b1;
    @(negedge clk);
    csr_gnt_i = 1'b0;
    chk("rst_post_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_post_rsp", 32'(rsp_valid_o), 32'd0);
    chk("rst_post_req", 32'(csr_req_o), 32'd0);
  endtask

  logic [ADDR_W-1:0] addr_pool [6];

  initial begin
    rst           = 1'b1;
    cmd_valid_i   = 1'b0;
    cmd_op_i      = 2'b00;
    cmd_addr_i    = '0;
    cmd_wdata_i   = '0;
    csr_gnt_i     = 1'b0;
    csr_rvalid_i  = 1'b0;
    csr_rdata_i   = '0;
    csr_illegal_i = 1'b0;
    rsp_ready_i   = 1'b0;

    #1;
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_csr_req", 32'(csr_req_o), 32'd0);
    chk("rst_csr_we", 32'(csr_we_o), 32'd0);
    chk("rst_csr_addr", 32'(csr_addr_o), 32'd0);
    chk("rst_csr_wdata", csr_wdata_o, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    mem[12'h300] = 32'h0000_1888;
    run_cmd(OP_READ, 12'h300, 32'h0, 0, 0, 0, 1'b0, 1'b0, 5);
    mem[12'h7B0] = 32'h0000_A703;
    run_cmd(OP_SET, 12'h7B0, 32'h0000_0004, 0, 0, 0, 1'b0, 1'b0, 0);
    chk("set_mem", mem_rd(12'h7B0), 32'h0000_A707);
    mem[12'h304] = 32'h7FFF_0888;
    run_cmd(OP_CLEAR, 12'h304, 32'h0000_0080, 3, 0, 3, 1'b0, 1'b0, 0);
    run_cmd(OP_WRITE, 12'hF14, 32'h1234_5678, 0, 0, 0, 1'b0, 1'b1, 0);
    mem[12'h3A0] = 32'h0000_0F0F;
    run_cmd(OP_SET, 12'h3A0, 32'hFFFF_0000, 0, 2, 0, 1'b1, 1'b0, 1);
    run_timeout(12'h300);
    run_reset_mid_write();
    chk("rst_no_write", mem_rd(12'h340), 32'd0);

    // Randomized commands against the CSR-file model.
    addr_pool[0] = 12'h300; addr_pool[1] = 12'h304; addr_pool[2] = 12'h7B0;
    addr_pool[3] = 12'h3A0; addr_pool[4] = 12'hF14; addr_pool[5] = 12'h341;
    for (int n = 0; n < 80; n++) begin
      run_cmd(2'($urandom), addr_pool[$urandom_range(0, 5)], $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so the bench always ends on its own.
  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
